// File: rtl/seq_shift_add_mult_if.sv
// Operand/result bundle between a multiply requester (master) and the shift-add multiplier (slave).
interface seq_shift_add_mult_if #(
    parameter int W0 = 8,
    parameter int W1 = 9
);
    localparam int OUT_W = W0 + W1;

    logic             start;
    logic [W0-1:0]    input_0;
    logic [W1-1:0]    input_1;
    logic             busy;
    logic             data_valid;
    logic [OUT_W-1:0] out;

    modport master (
        output start,
        output input_0,
        output input_1,
        input  busy,
        input  data_valid,
        input  out
    );

    modport slave (
        input  start,
        input  input_0,
        input  input_1,
        output busy,
        output data_valid,
        output out
    );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Bit-serial shift-add multiplier; MULT_SIGNED_EN selects two's-complement operands/product.
// Latency W0+2 clocks start-to-strobe; start is ignored (not queued) while busy.
module seq_shift_add_mult #(
    parameter int W0 = 8,
    parameter int W1 = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_shift_add_mult_if.slave  mif
);
    localparam int OUT_W = W0 + W1;
    localparam int CNT_W = (W0 > 1) ? $clog2(W0) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [W0-1:0]      a_q, a_d;
    logic [OUT_W-1:0]   b_q, b_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dv_q, dv_d;
    logic [W0-1:0]      op0;
    logic [W1-1:0]      op1;

`ifdef MULT_SIGNED_EN
    logic neg_q, neg_d;

    // Magnitudes stay unsigned, so the most-negative value maps to 2^(W-1) exactly.
    always_comb begin
        op0 = mif.input_0[W0-1] ? (~mif.input_0 + 1'b1) : mif.input_0;
        op1 = mif.input_1[W1-1] ? (~mif.input_1 + 1'b1) : mif.input_1;
    end
`else
    always_comb begin
        op0 = mif.input_0;
        op1 = mif.input_1;
    end
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        dv_d    = 1'b0;
`ifdef MULT_SIGNED_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (mif.start) begin
                    a_d     = op0;
                    b_d     = OUT_W'(op1);
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef MULT_SIGNED_EN
                    neg_d   = mif.input_0[W0-1] ^ mif.input_1[W1-1];
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Fixed W0 iterations even once a_q runs out of ones: latency is data-independent.
                if (a_q[0]) begin
                    acc_d = acc_q + b_q;
                end
                a_d   = a_q >> 1;
                b_d   = b_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(W0 - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
`ifdef MULT_SIGNED_EN
                out_d = neg_q ? (~acc_q + 1'b1) : acc_q;
`else
                out_d = acc_q;
`endif
                dv_d    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            dv_q    <= 1'b0;
`ifdef MULT_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            dv_q    <= dv_d;
`ifdef MULT_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign mif.busy       = (state_q != S_IDLE);
    assign mif.data_valid = dv_q;
    assign mif.out        = out_q;
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: cycle-level reference model plus directed literal cases.
module tb_seq_shift_add_mult;
    localparam int W0    = 8;
    localparam int W1    = 9;
    localparam int OUT_W = W0 + W1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seq_shift_add_mult_if #(.W0(W0), .W1(W1)) mif ();
    seq_shift_add_mult #(.W0(W0), .W1(W1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mif   (mif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Reference product: plain integer multiply, truncated to the product width.
    function automatic logic [OUT_W-1:0] ref_mult(input logic [W0-1:0] a, input logic [W1-1:0] b);
        longint x, y;
        x = longint'(a);
        y = longint'(b);
`ifdef MULT_SIGNED_EN
        if (a[W0-1]) x = x - (longint'(1) << W0);
        if (b[W1-1]) y = y - (longint'(1) << W1);
`endif
        return OUT_W'(x * y);
    endfunction

    // Model: an accepted start makes the block unavailable for W0+1 edges, then the product strobes.
    int               rem   = 0;
    logic             m_dv  = 1'b0;
    logic [OUT_W-1:0] m_out = '0;
    logic [OUT_W-1:0] pend  = '0;
    bit               cmp_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem   = 0;
            m_dv  = 1'b0;
            m_out = '0;
        end else begin
            m_dv = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    m_dv  = 1'b1;
                    m_out = pend;
                end
            end else if (mif.start) begin
                rem  = W0 + 1;
                pend = ref_mult(mif.input_0, mif.input_1);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_busy", mif.busy, rem > 0);
            check("model_data_valid", mif.data_valid, m_dv);
            check("model_out", mif.out, m_out);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [W0-1:0] a, input logic [W1-1:0] b,
                          input logic [OUT_W-1:0] lit);
        int n;
        bit seen;
        step();
        mif.start   = 1'b1;
        mif.input_0 = a;
        mif.input_1 = b;
        step();
        mif.start = 1'b0;
        n    = 1;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            if (mif.data_valid) seen = 1'b1;
            else begin
                step();
                n++;
            end
        end
        check({name, "_latency"}, n, W0 + 2);
        check({name, "_out"}, mif.out, lit);
        step();
        check({name, "_single_strobe"}, mif.data_valid, 1'b0);
    endtask

    function automatic logic [W0-1:0] pick0();
        case ($urandom_range(0, 4))
            0:       return '1;
            1:       return '0;
            2:       return {1'b1, {(W0-1){1'b0}}};
            default: return W0'($urandom);
        endcase
    endfunction

    function automatic logic [W1-1:0] pick1();
        case ($urandom_range(0, 4))
            0:       return '1;
            1:       return '0;
            2:       return {1'b1, {(W1-1){1'b0}}};
            default: return W1'($urandom);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int strobes;
        logic [OUT_W-1:0] last_out;

        // Reset with start held high.
        mif.start   = 1'b1;
        mif.input_0 = 8'd3;
        mif.input_1 = 9'd5;
        repeat (3) step();
        check("reset_busy", mif.busy, 1'b0);
        check("reset_data_valid", mif.data_valid, 1'b0);
        check("reset_out", mif.out, '0);
        mif.start = 1'b0;
        rst_n     = 1'b1;
        cmp_en    = 1'b1;
        repeat (5) step();
        check("idle_after_release_busy", mif.busy, 1'b0);

        // Handshake and hold.
        run_op("mul_3x5", 8'd3, 9'd5, 17'd15);
        repeat (20) step();
        check("hold_out_15", mif.out, 17'd15);

        // Corners.
`ifdef MULT_SIGNED_EN
        run_op("smul_m3x5", 8'hFD, 9'd5, 17'h1FFF1);
        run_op("smul_m128xm256", 8'h80, 9'h100, 17'd32768);
        run_op("smul_127xm1", 8'h7F, 9'h1FF, 17'h1FF81);
`else
        run_op("mul_255x511", 8'd255, 9'd511, 17'd130305);
`endif
        run_op("mul_0x511", 8'd0, 9'd511, 17'd0);
        run_op("mul_255x0", 8'd255, 9'd0, 17'd0);
        run_op("mul_1x1", 8'd1, 9'd1, 17'd1);

        // Start while busy is dropped.
        step();
        mif.start = 1'b1; mif.input_0 = 8'd7; mif.input_1 = 9'd9;
        step();
        mif.start = 1'b0; mif.input_0 = 8'd0; mif.input_1 = 9'd0;
        step();
        step();
        mif.start = 1'b1; mif.input_0 = 8'd2; mif.input_1 = 9'd2;
        step();
        mif.start = 1'b0;
        strobes  = 0;
        last_out = '0;
        for (int i = 0; i < 20; i++) begin
            if (mif.data_valid) begin
                strobes++;
                last_out = mif.out;
            end
            step();
        end
        check("busy_ignore_strobes", strobes, 1);
        check("busy_ignore_out", last_out, 17'd63);

        // Start held high: one result per W0+2 clocks.
        mif.start = 1'b1; mif.input_0 = 8'd3; mif.input_1 = 9'd4;
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (mif.data_valid) strobes++;
        end
        mif.start = 1'b0;
        check("held_start_strobes", strobes, 4);
        repeat (12) step();

        // Reset during RUN aborts the operation.
        mif.start = 1'b1; mif.input_0 = 8'd9; mif.input_1 = 9'd9;
        step();
        mif.start = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 15; i++) begin
            if (mif.data_valid) strobes++;
            step();
        end
        check("abort_no_strobe", strobes, 0);
        check("abort_out", mif.out, 17'd0);
        run_op("mul_6x6", 8'd6, 9'd6, 17'd36);

        // Random traffic with operands changing freely and rare resets.
        strobes = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (mif.data_valid) strobes++;
            rst_n       = ($urandom_range(0, 999) != 0);
            mif.start   = ($urandom_range(0, 3) == 0);
            mif.input_0 = pick0();
            mif.input_1 = pick1();
        end
        rst_n     = 1'b1;
        mif.start = 1'b0;
        repeat (15) step();
        check("random_traffic_active", strobes > 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
